// File: rtl/spike_rate_decoder_if.sv
// Spike decoder bus: enable and spike level towards the decoder, with rate and
// inter-spike-interval results coming back.
//   en, spike              : count enable and neuron spike level
//   rate, rate_valid       : spike count of the last completed window and its update pulse
//   rate_ovf               : last completed window saturated
//   isi, isi_valid         : interval between the two most recent spikes and its update pulse
interface spike_rate_decoder_if;
  logic       en;
  logic       spike;
  logic [7:0] rate;
  logic       rate_valid;
  logic       rate_ovf;
  logic [7:0] isi;
  logic       isi_valid;

  modport master (
    output en, spike,
    input  rate, rate_valid, rate_ovf, isi, isi_valid
  );

  modport slave (
    input  en, spike,
    output rate, rate_valid, rate_ovf, isi, isi_valid
  );
endinterface

// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: turns the neuron's binary spike output into a windowed
// spike count (rate code) and the interval between the last two spikes (ISI).
//   WINDOW : window length in enabled cycles (2..65536)
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset
//   bus    : slave side of spike_rate_decoder_if (en/spike in, rate/isi results out)
// All outputs are registered.
module spike_rate_decoder #(
  parameter int unsigned WINDOW = 256
) (
  input logic                 clk,
  input logic                 rst,
  spike_rate_decoder_if.slave bus
);

  localparam int unsigned     WcntW    = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WcntW-1:0] WcntLast = WcntW'(WINDOW - 1);

  logic             spk_q;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [7:0]       scnt_q, scnt_d;
  logic             sat_q, sat_d;
  logic [7:0]       icnt_q, icnt_d;
  logic             seen_q, seen_d;
  logic [7:0]       rate_q, rate_d;
  logic             rate_valid_q, rate_valid_d;
  logic             rate_ovf_q, rate_ovf_d;
  logic [7:0]       isi_q, isi_d;
  logic             isi_valid_q, isi_valid_d;

  logic       spk_edge;
  logic       closing;
  logic [7:0] scnt_sum;
  logic       sat_now;
  logic [7:0] icnt_inc;

  // spk_q tracks the raw level even while disabled, so a spike already high
  // when en re-asserts does not produce an edge.
  assign spk_edge = bus.spike & ~spk_q & bus.en;
  assign closing  = bus.en & (wcnt_q == WcntLast);
  assign scnt_sum = (scnt_q == 8'hff) ? 8'hff : scnt_q + {7'd0, spk_edge};
  // Saturation including this cycle's edge, so a closing-cycle edge is reported.
  assign sat_now  = sat_q | (scnt_sum == 8'hff);
  assign icnt_inc = (icnt_q == 8'hff) ? 8'hff : icnt_q + 8'd1;

  always_comb begin
    wcnt_d       = wcnt_q;
    scnt_d       = scnt_q;
    sat_d        = sat_q;
    icnt_d       = icnt_q;
    seen_d       = seen_q;
    rate_d       = rate_q;
    rate_ovf_d   = rate_ovf_q;
    rate_valid_d = 1'b0;
    isi_d        = isi_q;
    isi_valid_d  = 1'b0;

    if (bus.en) begin
      wcnt_d = wcnt_q + WcntW'(1);
      scnt_d = scnt_sum;
      sat_d  = sat_now;
      icnt_d = spk_edge ? 8'd0 : icnt_inc;
    end

    if (closing) begin
      rate_d       = scnt_sum;
      rate_ovf_d   = sat_now;
      rate_valid_d = 1'b1;
      wcnt_d       = '0;
      scnt_d       = 8'd0;
      sat_d        = 1'b0;
    end

    if (spk_edge) begin
      seen_d = 1'b1;
      // icnt counts the cycles strictly between edges; +1 gives the spacing.
      if (seen_q) begin
        isi_d       = icnt_inc;
        isi_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spk_q        <= 1'b0;
      wcnt_q       <= '0;
      scnt_q       <= 8'd0;
      sat_q        <= 1'b0;
      icnt_q       <= 8'd0;
      seen_q       <= 1'b0;
      rate_q       <= 8'd0;
      rate_valid_q <= 1'b0;
      rate_ovf_q   <= 1'b0;
      isi_q        <= 8'd0;
      isi_valid_q  <= 1'b0;
    end else begin
      spk_q        <= bus.spike;
      wcnt_q       <= wcnt_d;
      scnt_q       <= scnt_d;
      sat_q        <= sat_d;
      icnt_q       <= icnt_d;
      seen_q       <= seen_d;
      rate_q       <= rate_d;
      rate_valid_q <= rate_valid_d;
      rate_ovf_q   <= rate_ovf_d;
      isi_q        <= isi_d;
      isi_valid_q  <= isi_valid_d;
    end
  end

  assign bus.rate       = rate_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.rate_ovf   = rate_ovf_q;
  assign bus.isi        = isi_q;
  assign bus.isi_valid  = isi_valid_q;

endmodule

// File: doc/spike_rate_decoder.md
# spike_rate_decoder

Spike-train decoder for the LIF neuron datapath. It converts the neuron's binary spike output back into numeric values: a windowed spike count (rate code) and the interval between the two most recent spikes (temporal code). It sits downstream of the neuron's spike pin. Its outputs drive the bidirectional output pins or feed a following neuron's current input.

## Interface
- `WINDOW`, default 256: window length in enabled clock cycles, legal range 2..65536.
- `clk` input 1: clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `en` input 1: count enable. When low, all counters freeze.
- `spike` input 1: spike level from the neuron. It may be a one-cycle pulse or a multi-cycle level.
- `rate` output 8: number of spikes in the last completed window, saturated at 255.
- `rate_valid` output 1: one-cycle pulse when `rate` updates.
- `rate_ovf` output 1: set when the last completed window saturated.
- `isi` output 8: cycles between the two most recent spikes, saturated at 255.
- `isi_valid` output 1: one-cycle pulse when `isi` updates.

## Operation
- **Edge detect**
  - `spk_q` registers `spike` every cycle, regardless of `en`.
  - `edge = spike & ~spk_q & en`.
  - A held-high spike counts once.
  - Minimum edge spacing is 2 cycles.
- **Window counter `wcnt`** (width ceil(log2(WINDOW)))
  - Increments on each enabled cycle. Holds when `en` = 0.
  - The closing cycle is an enabled cycle with `wcnt == WINDOW-1`.
- **Spike counter `scnt`** (8 bit)
  - Adds 1 on `edge`, saturating at 255.
  - Sticky `sat` flag sets when an edge arrives while `scnt == 255`, or when `scnt` reaches 255.
- **Closing cycle**
  - `rate <= sat8(scnt + edge)`. An edge in the closing cycle belongs to the closing window.
  - `rate_ovf <=` saturation including that edge.
  - `rate_valid <= 1`.
  - `wcnt`, `scnt` and `sat` are cleared.
- **Interval counter `icnt`** (8 bit)
  - On each enabled non-edge cycle, increments, saturating at 255.
  - On `edge`, clears to 0.
- **On an edge**
  - If flag `seen` = 1: `isi <= sat8(icnt + 1)` and `isi_valid <= 1`.
  - In all cases, `seen <= 1`.
  - The first edge after reset produces no `isi_valid`.
- **Outputs outside update events**
  - `rate_valid` and `isi_valid` are 0 on all other cycles.
  - `rate`, `rate_ovf` and `isi` hold their last values.
- **Reset values**
  - Outputs: `rate` = 0, `rate_valid` = 0, `rate_ovf` = 0, `isi` = 0, `isi_valid` = 0.
  - Internal state: `wcnt`, `scnt`, `sat`, `icnt`, `seen` and `spk_q` are all 0.
- **`en` = 0**
  - No edges are counted and no valid pulses are issued.
  - `spk_q` keeps tracking. A spike that rises and falls entirely while disabled is lost.
  - A spike that is high when `en` re-asserts and was already high before is not counted.

## Timing
- **Rate latency:** `rate`/`rate_valid` appear in the cycle after the closing cycle.
- **Window spacing:** with `en` held high, `rate_valid` pulses exactly every WINDOW cycles. The first pulse comes WINDOW cycles after reset deassertion, i.e. on the clock edge that ends enabled cycle number WINDOW.
- **ISI latency:** `isi`/`isi_valid` appear one cycle after the edge cycle.
- **ISI value:** for edges at enabled cycles t0 and t0+k with `en` continuously high, `isi = min(k, 255)`. Disabled cycles are not counted.
- **Simultaneous events:** an edge in the closing cycle updates `rate` and `isi` in the same cycle. Both valids pulse together.
- **Reset mid-operation:** `rst` wins over everything in its cycle.
  - The partial window is discarded.
  - `seen` clears, so the next edge is again a "first" edge.
  - No valid pulse is issued in the cycle after `rst` is sampled high.
- **Registers:** all outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Periodic spikes:** WINDOW=16, `en`=1, one-cycle `spike` every 4 cycles starting at cycle 0 → `rate`=4 and `rate_valid` every 16 cycles. `isi`=4 with an `isi_valid` per spike except the first. `rate_ovf`=0.
- **Level spike and closing-cycle edge:** WINDOW=16, `spike` held high for 5 cycles → counts 1. A separate edge placed exactly at `wcnt`=15 → counted in that window and `rate`+`isi` update on the same cycle.
- **Saturation:** WINDOW=1024, `spike` toggling every cycle (512 edges) → `rate`=255, `rate_ovf`=1. The next window with 3 spikes → `rate`=3, `rate_ovf`=0. Spike gap of 400 cycles → `isi`=255.
- **Enable gating:** WINDOW=16, `en` low for 10 cycles mid-window with spikes present → window duration stretches to 26 wall cycles. Disabled spikes are not counted. `isi` excludes the disabled cycles.
- **Mid-window reset:** WINDOW=16, 3 spikes, `rst` at `wcnt`=8 → no `rate_valid`. All outputs read 0. The first post-reset spike gives no `isi_valid`. The next window's `rate` counts only post-reset spikes.
- **Cascade check:** drive `spike` from the LIF neuron with constant current 8'd200 → `rate` is stable (±1) across successive windows, and `isi` is constant across successive spikes.
